// File: rtl/cache_tag_array_pkg.sv
// Shared types and constant helpers for the set-associative tag store.
// Width helpers are plain constant functions so parameter-derived widths stay elaboration-time.
package cache_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Resettable half of a tag entry; the tag itself lives in unreset RAM beside it.
    typedef struct packed {
        logic valid;
        logic dirty;
    } line_state_t;

endpackage

// File: rtl/cache_tag_array_if.sv
// Lookup/update/flush bus between the cache controller (master) and the tag store (slave).
interface cache_tag_array_if #(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int TAG_W = 55
);
    import cache_pkg::*;

    localparam int IDX_W = clog2(SETS);
    localparam int WAY_W = max2(1, clog2(WAYS));

    logic             lookup_valid_i;
    logic [IDX_W-1:0] lookup_index_i;
    logic [TAG_W-1:0] lookup_tag_i;
    logic             hit_valid_o;
    logic             hit_o;
    logic [WAY_W-1:0] hit_way_o;
    logic             hit_dirty_o;
    logic [WAY_W-1:0] victim_way_o;
    logic             victim_valid_o;
    logic             victim_dirty_o;
    logic [TAG_W-1:0] victim_tag_o;
    logic             upd_we_i;
    logic [IDX_W-1:0] upd_index_i;
    logic [WAY_W-1:0] upd_way_i;
    logic [TAG_W-1:0] upd_tag_i;
    logic             upd_valid_i;
    logic             upd_dirty_i;
    logic             flush_i;
    logic             busy_o;

    modport master (
        output lookup_valid_i, lookup_index_i, lookup_tag_i,
        output upd_we_i, upd_index_i, upd_way_i, upd_tag_i, upd_valid_i, upd_dirty_i, flush_i,
        input  hit_valid_o, hit_o, hit_way_o, hit_dirty_o,
        input  victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o, busy_o
    );

    modport slave (
        input  lookup_valid_i, lookup_index_i, lookup_tag_i,
        input  upd_we_i, upd_index_i, upd_way_i, upd_tag_i, upd_valid_i, upd_dirty_i, flush_i,
        output hit_valid_o, hit_o, hit_way_o, hit_dirty_o,
        output victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o, busy_o
    );
endinterface

// File: rtl/cache_tag_array_plru.sv
// Tree pseudo-LRU next-state and victim decode; serves the lookup and update paths at once.
// Each tree bit points at the half holding the replacement candidate.
module plru_tree
    import cache_pkg::*;
#(
    parameter  int WAYS  = 2,
    localparam int WAY_W = max2(1, clog2(WAYS)),
    localparam int LRU_W = max2(1, WAYS - 1)
) (
    input  logic [LRU_W-1:0] lk_bits_i,
    input  logic             lk_touch_i,
    input  logic [WAY_W-1:0] lk_way_i,
    output logic [LRU_W-1:0] lk_next_o,
    output logic [WAY_W-1:0] lk_victim_o,
    input  logic [LRU_W-1:0] upd_bits_i,
    input  logic [WAY_W-1:0] upd_way_i,
    output logic [LRU_W-1:0] upd_next_o
);
    // A touch rewrites only the nodes on the touched way's path (mask) to point away (val).
    logic [LRU_W-1:0] lk_mask, lk_val, upd_mask, upd_val;

    if (WAYS == 4) begin : g_four
        assign lk_mask     = {lk_way_i[1], ~lk_way_i[1], 1'b1};
        assign lk_val      = {~lk_way_i[0], ~lk_way_i[0], ~lk_way_i[1]};
        assign upd_mask    = {upd_way_i[1], ~upd_way_i[1], 1'b1};
        assign upd_val     = {~upd_way_i[0], ~upd_way_i[0], ~upd_way_i[1]};
        assign lk_victim_o = lk_next_o[0] ? {1'b1, lk_next_o[2]} : {1'b0, lk_next_o[1]};
    end else if (WAYS == 2) begin : g_two
        assign lk_mask     = 1'b1;
        assign lk_val      = ~lk_way_i;
        assign upd_mask    = 1'b1;
        assign upd_val     = ~upd_way_i;
        assign lk_victim_o = lk_next_o;
    end else begin : g_one
        assign lk_mask     = '0;
        assign lk_val      = '0;
        assign upd_mask    = '0;
        assign upd_val     = '0;
        assign lk_victim_o = '0;
    end

    assign lk_next_o  = lk_touch_i ? ((lk_bits_i & ~lk_mask) | (lk_val & lk_mask)) : lk_bits_i;
    assign upd_next_o = (upd_bits_i & ~upd_mask) | (upd_val & upd_mask);
endmodule

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store: registered hit/victim lookup, tree PLRU, and a
// one-set-per-cycle invalidate-all sequencer that blocks the bus while it runs.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int TAG_W = 55
) (
    input logic              clk_i,
    input logic              rst_n_i,
    cache_tag_array_if.slave bus
);
    localparam int IDX_W = clog2(SETS);
    localparam int WAY_W = max2(1, clog2(WAYS));
    localparam int LRU_W = max2(1, WAYS - 1);

    state_t                 state_reg;
    logic                   busy_reg;
    logic [IDX_W-1:0]       flush_cnt_reg;
    line_state_t [WAYS-1:0] line_reg [SETS];
    logic [LRU_W-1:0]       plru_reg [SETS];

    logic             hit_valid_reg, hit_reg, hit_dirty_reg;
    logic             victim_valid_reg, victim_dirty_reg;
    logic [WAY_W-1:0] hit_way_reg, victim_way_reg;
    logic [TAG_W-1:0] victim_tag_reg;

    logic             lk_acc, upd_acc, hit_any, inv_any;
    logic [WAYS-1:0]  rd_valid, rd_dirty, hit_vec;
    logic [TAG_W-1:0] rd_tag [WAYS];
    logic [WAY_W-1:0] hit_way, inv_way, victim_way, plru_victim;
    logic [LRU_W-1:0] lk_plru_next, upd_plru_next;

    assign lk_acc  = bus.lookup_valid_i && !busy_reg;
    assign upd_acc = bus.upd_we_i && !busy_reg;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0] tag_mem [SETS];

        always_ff @(posedge clk_i) begin
            if (upd_acc && bus.upd_way_i == WAY_W'(gi)) begin
                tag_mem[bus.upd_index_i] <= bus.upd_tag_i;
            end
        end

        assign rd_tag[gi]   = tag_mem[bus.lookup_index_i];
        assign rd_valid[gi] = line_reg[bus.lookup_index_i][gi].valid;
        assign rd_dirty[gi] = line_reg[bus.lookup_index_i][gi].dirty;
        assign hit_vec[gi]  = rd_valid[gi] && (rd_tag[gi] == bus.lookup_tag_i);
    end

    // Descending scan so the lowest-index hit / invalid way is the one left standing.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])   hit_way = WAY_W'(w);
            if (!rd_valid[w]) inv_way = WAY_W'(w);
        end
    end

    assign hit_any    = |hit_vec;
    assign inv_any    = ~&rd_valid;
    assign victim_way = inv_any ? inv_way : plru_victim;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .lk_bits_i  (plru_reg[bus.lookup_index_i]),
        .lk_touch_i (hit_any),
        .lk_way_i   (hit_way),
        .lk_next_o  (lk_plru_next),
        .lk_victim_o(plru_victim),
        .upd_bits_i (plru_reg[bus.upd_index_i]),
        .upd_way_i  (bus.upd_way_i),
        .upd_next_o (upd_plru_next)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            flush_cnt_reg <= '0;
            for (int s = 0; s < SETS; s++) begin
                line_reg[s] <= '0;
                plru_reg[s] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.flush_i) begin
                        state_reg     <= FLUSH;
                        busy_reg      <= 1'b1;
                        flush_cnt_reg <= '0;
                    end
                end
                FLUSH: begin
                    line_reg[flush_cnt_reg] <= '0;
                    plru_reg[flush_cnt_reg] <= '0;
                    flush_cnt_reg           <= flush_cnt_reg + 1'b1;
                    if (flush_cnt_reg == IDX_W'(SETS - 1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Update touch is written last so it overrides a same-set lookup touch.
            if (lk_acc && hit_any) begin
                plru_reg[bus.lookup_index_i] <= lk_plru_next;
            end
            if (upd_acc) begin
                line_reg[bus.upd_index_i][bus.upd_way_i] <=
                    line_state_t'{valid: bus.upd_valid_i, dirty: bus.upd_valid_i && bus.upd_dirty_i};
                if (bus.upd_valid_i) begin
                    plru_reg[bus.upd_index_i] <= upd_plru_next;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_valid_reg    <= 1'b0;
            hit_reg          <= 1'b0;
            hit_way_reg      <= '0;
            hit_dirty_reg    <= 1'b0;
            victim_way_reg   <= '0;
            victim_valid_reg <= 1'b0;
            victim_dirty_reg <= 1'b0;
            victim_tag_reg   <= '0;
        end else begin
            hit_valid_reg <= lk_acc;
            if (lk_acc) begin
                hit_reg          <= hit_any;
                hit_way_reg      <= hit_way;
                hit_dirty_reg    <= hit_any && rd_dirty[hit_way];
                victim_way_reg   <= victim_way;
                victim_valid_reg <= rd_valid[victim_way];
                victim_dirty_reg <= rd_valid[victim_way] && rd_dirty[victim_way];
                victim_tag_reg   <= rd_tag[victim_way];
            end
        end
    end

    assign bus.hit_valid_o    = hit_valid_reg;
    assign bus.hit_o          = hit_reg;
    assign bus.hit_way_o      = hit_way_reg;
    assign bus.hit_dirty_o    = hit_dirty_reg;
    assign bus.victim_way_o   = victim_way_reg;
    assign bus.victim_valid_o = victim_valid_reg;
    assign bus.victim_dirty_o = victim_dirty_reg;
    assign bus.victim_tag_o   = victim_tag_reg;
    assign bus.busy_o         = busy_reg;

    a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_n_i) lk_acc |-> $onehot0(hit_vec));
endmodule

// File: tb/tb_cache_tag_array.sv
// Bench for cache_tag_array (16 sets, 2 ways): directed scenarios with literal expectations,
// then random traffic checked every cycle against a set/way table model.
module tb_cache_tag_array;
    localparam int SETS  = 16;
    localparam int WAYS  = 2;
    localparam int TAG_W = 55;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_tag_array_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

    cache_tag_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: per set/way table. With two ways the tree degenerates to true LRU,
    // so each set just remembers which way is next to be replaced.
    bit               m_valid [SETS][WAYS];
    bit               m_dirty [SETS][WAYS];
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    int               m_repl  [SETS];
    int               m_flush_left, m_flush_set;

    bit               e_hv, e_hit, e_hd, e_vv, e_vd, e_busy;
    int               e_hw, e_vw;
    logic [TAG_W-1:0] e_vtag;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_repl[s] = 0;
        end
        m_flush_left = 0;
        m_flush_set  = 0;
        {e_hv, e_hit, e_hd, e_vv, e_vd, e_busy} = '0;
        e_hw   = 0;
        e_vw   = 0;
        e_vtag = '0;
    endtask

    task automatic model_step();
        bit busy;
        int idx, ui, uw, hw, vw;
        busy = (m_flush_left > 0);
        idx  = int'(bus.lookup_index_i);
        ui   = int'(bus.upd_index_i);
        uw   = int'(bus.upd_way_i);
        hw   = -1;
        vw   = -1;
        if (bus.lookup_valid_i && !busy) begin
            for (int w = 0; w < WAYS; w++)
                if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == bus.lookup_tag_i) hw = w;
            if (hw >= 0) m_repl[idx] = 1 - hw;
            for (int w = 0; w < WAYS; w++)
                if (vw < 0 && !m_valid[idx][w]) vw = w;
            if (vw < 0) vw = m_repl[idx];
            e_hv   = 1'b1;
            e_hit  = (hw >= 0);
            e_hw   = (hw >= 0) ? hw : 0;
            e_hd   = 1'b0;
            if (hw >= 0) e_hd = m_dirty[idx][hw];
            e_vw   = vw;
            e_vv   = m_valid[idx][vw];
            e_vd   = m_valid[idx][vw] && m_dirty[idx][vw];
            e_vtag = m_tag[idx][vw];
        end else begin
            e_hv = 1'b0;
        end
        if (busy) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[m_flush_set][w] = 1'b0;
                m_dirty[m_flush_set][w] = 1'b0;
            end
            m_repl[m_flush_set] = 0;
            m_flush_set++;
            m_flush_left--;
        end else if (bus.flush_i) begin
            m_flush_left = SETS;
            m_flush_set  = 0;
        end
        if (bus.upd_we_i && !busy) begin
            m_valid[ui][uw] = bus.upd_valid_i;
            m_dirty[ui][uw] = bus.upd_valid_i && bus.upd_dirty_i;
            m_tag[ui][uw]   = bus.upd_tag_i;
            if (bus.upd_valid_i) m_repl[ui] = 1 - uw;
        end
        e_busy = (m_flush_left > 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("hit_valid", bus.hit_valid_o, e_hv);
            check("hit", bus.hit_o, e_hit);
            check("hit_way", bus.hit_way_o, e_hw);
            check("hit_dirty", bus.hit_dirty_o, e_hd);
            check("victim_way", bus.victim_way_o, e_vw);
            check("victim_valid", bus.victim_valid_o, e_vv);
            check("victim_dirty", bus.victim_dirty_o, e_vd);
            check("busy", bus.busy_o, e_busy);
            if (e_vv) check("victim_tag", bus.victim_tag_o, e_vtag);
        end
    end

    task automatic idle_in();
        bus.lookup_valid_i = 1'b0;
        bus.lookup_index_i = '0;
        bus.lookup_tag_i   = '0;
        bus.upd_we_i       = 1'b0;
        bus.upd_index_i    = '0;
        bus.upd_way_i      = '0;
        bus.upd_tag_i      = '0;
        bus.upd_valid_i    = 1'b0;
        bus.upd_dirty_i    = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle_in();
    endtask

    task automatic lookup(input int idx, input logic [TAG_W-1:0] tag);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_index_i = 4'(idx);
        bus.lookup_tag_i   = tag;
    endtask

    task automatic update(input int idx, input int way, input logic [TAG_W-1:0] tag, input bit v, input bit d);
        bus.upd_we_i    = 1'b1;
        bus.upd_index_i = 4'(idx);
        bus.upd_way_i   = 1'(way);
        bus.upd_tag_i   = tag;
        bus.upd_valid_i = v;
        bus.upd_dirty_i = d;
    endtask

    initial begin
        int n;
        logic [TAG_W-1:0] t;
        int ui, uw;
        bit uv;

        idle_in();
        #1 rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hit_valid", bus.hit_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_victim_tag", bus.victim_tag_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty set: miss, victim is invalid way 0.
        lookup(3, 'h1A); step();
        check("t1_hit_valid", bus.hit_valid_o, 1);
        check("t1_hit", bus.hit_o, 0);
        check("t1_victim_way", bus.victim_way_o, 0);
        check("t1_victim_valid", bus.victim_valid_o, 0);

        update(3, 0, 'h1A, 1'b1, 1'b0); step();
        lookup(3, 'h1A); step();
        check("t2_hit", bus.hit_o, 1);
        check("t2_hit_way", bus.hit_way_o, 0);
        check("t2_hit_dirty", bus.hit_dirty_o, 0);
        check("t2_victim_way", bus.victim_way_o, 1);

        // Both ways full: the victim is the way not touched by the hit.
        update(5, 0, 'h10, 1'b1, 1'b0); step();
        update(5, 1, 'h20, 1'b1, 1'b0); step();
        lookup(5, 'h10); step();
        check("t3_victim_way_a", bus.victim_way_o, 1);
        lookup(5, 'h20); step();
        check("t3_victim_way_b", bus.victim_way_o, 0);
        check("t3_victim_tag", bus.victim_tag_o, 'h10);
        check("t3_victim_valid", bus.victim_valid_o, 1);

        // Same-cycle update and lookup: lookup sees the pre-update set.
        update(2, 1, 'h33, 1'b1, 1'b1);
        lookup(2, 'h33); step();
        check("t4_hit_pre", bus.hit_o, 0);
        lookup(2, 'h33); step();
        check("t4_hit_post", bus.hit_o, 1);
        check("t4_hit_dirty", bus.hit_dirty_o, 1);
        check("t4_hit_way", bus.hit_way_o, 1);

        // Flush: busy for exactly SETS cycles, bus traffic dropped meanwhile.
        bus.flush_i = 1'b1; step();
        n = 0;
        while (bus.busy_o && n < 40) begin
            n++;
            lookup(7, 'h77);
            update(7, 0, 'h77, 1'b1, 1'b0);
            bus.flush_i = 1'b1;
            step();
            check("t5_dropped_lookup", bus.hit_valid_o, 0);
        end
        check("t5_busy_cycles", n, SETS);
        for (int s = 0; s < SETS; s++) begin
            lookup(s, (s == 7) ? 'h77 : ((s == 2) ? 'h33 : 'h1A)); step();
            check("t5_post_hit", bus.hit_o, 0);
            check("t5_post_victim_valid", bus.victim_valid_o, 0);
        end

        // Async reset in the middle of a flush.
        update(12, 0, 'h5C, 1'b1, 1'b0); step();
        lookup(12, 'h5C); step();
        check("t6_pre_hit", bus.hit_o, 1);
        bus.flush_i = 1'b1; step();
        repeat (6) step();
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_busy", bus.busy_o, 0);
        check("t6_rst_hit_valid", bus.hit_valid_o, 0);
        check("t6_rst_hit", bus.hit_o, 0);
        check("t6_rst_victim_tag", bus.victim_tag_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(12, 'h5C); step();
        check("t6_after_hit_valid", bus.hit_valid_o, 1);
        check("t6_after_hit", bus.hit_o, 0);
        check("t6_after_victim_valid", bus.victim_valid_o, 0);

        // Random traffic over a few hot sets with a small tag pool to force hits and evictions.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                t = '0;
                t[TAG_W-1] = 1'($urandom_range(0, 1));
                t[1:0]     = 2'($urandom_range(0, 3));
                lookup(($urandom_range(0, 3) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 3), t);
            end
            if ($urandom_range(0, 2) == 0) begin
                t = '0;
                t[TAG_W-1] = 1'($urandom_range(0, 1));
                t[1:0]     = 2'($urandom_range(0, 3));
                ui = ($urandom_range(0, 3) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 3);
                uw = $urandom_range(0, WAYS - 1);
                uv = ($urandom_range(0, 3) != 0);
                // Never create a second valid copy of a tag within one set.
                if (uv && m_valid[ui][1 - uw] && m_tag[ui][1 - uw] == t) uv = 1'b0;
                update(ui, uw, t, uv, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 79) == 0) bus.flush_i = 1'b1;
            step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
